// File: rtl/histogram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : histogram_ctrl
//  Description : Sequencer for a 2^ADDR_WIDTH x DATA_WIDTH dual-port
//                histogram RAM. Accumulates one pixel per cycle as a
//                read-modify-write with same-bin forwarding, streams every
//                bin out after end-of-frame (clearing on read) and zeroes
//                the RAM after reset. Port A only reads, port B only writes.
//  Revision    : 1.0  initial release
// ============================================================================
module histogram_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // pixel stream
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [ADDR_WIDTH-1:0] pix_data,
  input  logic                  pix_eof,
  // bin result stream
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_bin,
  output logic [DATA_WIDTH-1:0] out_count,
  output logic                  out_last,
  output logic                  busy,
  // RAM port A (read only)
  output logic [ADDR_WIDTH-1:0] ram_a_addr,
  input  logic [DATA_WIDTH-1:0] ram_a_rd_data,
  output logic                  ram_a_wr_en,
  // RAM port B (write only)
  output logic [ADDR_WIDTH-1:0] ram_b_addr,
  output logic [DATA_WIDTH-1:0] ram_b_wr_data,
  output logic                  ram_b_wr_en
);

  localparam logic [ADDR_WIDTH-1:0] c_IDX_MAX = '1;
  localparam logic [ADDR_WIDTH-1:0] c_IDX_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] c_CNT_MAX = '1;
  localparam logic [DATA_WIDTH-1:0] c_CNT_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_IDLE  = 3'd1,
    S_ACC   = 3'd2,
    S_DRAIN = 3'd3,
    S_RD    = 3'd4,
    S_CAP   = 3'd5,
    S_OUT   = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_idx;

  // stage 1: pixel accepted last cycle, RAM read data now available
  logic                  r_s1_valid;
  logic [ADDR_WIDTH-1:0] r_s1_bin;

  // write-back stage: the value committed last cycle, used to forward
  // past the RAM when the next pixel hits the same bin
  logic                  r_wb_valid;
  logic [ADDR_WIDTH-1:0] r_wb_bin;
  logic [DATA_WIDTH-1:0] r_wb_data;

  logic [ADDR_WIDTH-1:0] r_out_bin;
  logic [DATA_WIDTH-1:0] r_out_count;

  logic                  w_xfer;
  logic [DATA_WIDTH-1:0] w_cur;
  logic [DATA_WIDTH-1:0] w_new;

  // Current count comes from the write-back register when the previous
  // update targeted the same bin (RAM read was issued before that write).
  assign w_cur = (r_wb_valid && (r_wb_bin == r_s1_bin)) ? r_wb_data : ram_a_rd_data;
  assign w_new = (w_cur == c_CNT_MAX) ? w_cur : (w_cur + c_CNT_ONE);

  assign ram_a_wr_en = 1'b0;
  assign busy        = (r_state != S_IDLE);
  assign out_bin     = r_out_bin;
  assign out_count   = r_out_count;

  // Next-state logic and RAM/handshake control.
  always_comb begin
    w_state_nxt   = r_state;
    w_xfer        = 1'b0;
    pix_ready     = 1'b0;
    out_valid     = 1'b0;
    out_last      = 1'b0;
    ram_a_addr    = r_idx;
    ram_b_addr    = r_idx;
    ram_b_wr_data = '0;
    ram_b_wr_en   = 1'b0;

    case (r_state)
      S_CLEAR: begin
        // hold writes off while reset is still asserted
        ram_b_wr_en = !rst;
        if (r_idx == c_IDX_MAX) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_IDLE, S_ACC: begin
        pix_ready  = 1'b1;
        ram_a_addr = pix_data;
        w_xfer     = pix_valid;
        if (pix_valid) begin
          w_state_nxt = pix_eof ? S_DRAIN : S_ACC;
        end
      end
      S_DRAIN: begin
        w_state_nxt = S_RD;
      end
      S_RD: begin
        w_state_nxt = S_CAP;
      end
      S_CAP: begin
        // clear-on-read: zero the bin being captured
        ram_b_wr_en = 1'b1;
        w_state_nxt = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        out_last  = (r_idx == c_IDX_MAX);
        if (out_ready) begin
          w_state_nxt = (r_idx == c_IDX_MAX) ? S_IDLE : S_RD;
        end
      end
      default: begin
        w_state_nxt = S_CLEAR;
      end
    endcase

    // Accumulate write-back; never overlaps CLEAR or CAP writes.
    if (r_s1_valid) begin
      ram_b_addr    = r_s1_bin;
      ram_b_wr_data = w_new;
      ram_b_wr_en   = 1'b1;
    end
  end

  // State register, bin index and dump output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_CLEAR;
      r_idx       <= '0;
      r_out_bin   <= '0;
      r_out_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_CLEAR: r_idx <= r_idx + c_IDX_ONE;
        S_DRAIN: r_idx <= '0;
        S_CAP: begin
          r_out_count <= ram_a_rd_data;
          r_out_bin   <= r_idx;
        end
        S_OUT: begin
          if (out_ready) begin
            r_idx <= r_idx + c_IDX_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Accumulate pipeline: stage-1 capture and write-back forwarding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_bin   <= '0;
      r_wb_valid <= 1'b0;
      r_wb_bin   <= '0;
      r_wb_data  <= '0;
    end else begin
      r_s1_valid <= w_xfer;
      if (w_xfer) begin
        r_s1_bin <= pix_data;
      end
      r_wb_valid <= r_s1_valid;
      r_wb_bin   <= r_s1_bin;
      r_wb_data  <= w_new;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_histogram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_histogram_ctrl
//  Description : Self-checking bench for histogram_ctrl with a behavioural
//                256x32 RAM model and a scoreboard of expected dump results.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_histogram_ctrl;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NB = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [AW-1:0] pix_data = '0;
  logic          pix_eof = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_bin;
  logic [DW-1:0] out_count;
  logic          out_last;
  logic          busy;
  logic [AW-1:0] ram_a_addr;
  logic [DW-1:0] ram_a_rd_data;
  logic          ram_a_wr_en;
  logic [AW-1:0] ram_b_addr;
  logic [DW-1:0] ram_b_wr_data;
  logic          ram_b_wr_en;

  always #5 clk = ~clk;

  histogram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .pix_data      (pix_data),
    .pix_eof       (pix_eof),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_bin       (out_bin),
    .out_count     (out_count),
    .out_last      (out_last),
    .busy          (busy),
    .ram_a_addr    (ram_a_addr),
    .ram_a_rd_data (ram_a_rd_data),
    .ram_a_wr_en   (ram_a_wr_en),
    .ram_b_addr    (ram_b_addr),
    .ram_b_wr_data (ram_b_wr_data),
    .ram_b_wr_en   (ram_b_wr_en)
  );

  // RAM model: 1-cycle read latency, read returns old data on collision.
  logic [DW-1:0] mem [NB];
  logic          fill_req = 1'b1;
  logic          bd_req   = 1'b0;
  logic [AW-1:0] bd_addr  = '0;
  logic [DW-1:0] bd_data  = '0;

  always @(posedge clk) begin
    ram_a_rd_data <= mem[ram_a_addr];
    if (fill_req) begin
      for (int i = 0; i < NB; i++) mem[i] <= 32'hA5A5_0000 | i;
    end else if (bd_req) begin
      mem[bd_addr] <= bd_data;
    end else if (ram_b_wr_en) begin
      mem[ram_b_addr] <= ram_b_wr_data;
    end
  end

  typedef struct packed {
    logic [AW-1:0] bin;
    logic [DW-1:0] cnt;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] hist [NB];
  int            n_cmp  = 0;
  int            n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Output monitor: scoreboard pop, stability under backpressure, no
  // pixel acceptance while dumping.
  logic          hold = 1'b0;
  logic [AW-1:0] h_bin;
  logic [DW-1:0] h_cnt;
  exp_t          e;

  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_bin", out_bin, h_bin);
        check("hold_count", out_count, h_cnt);
      end
      hold = 1'b0;
      if (out_valid) begin
        check("pix_ready_in_dump", pix_ready, 0);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out_valid", out_valid, 0);
          end else begin
            e = exp_q.pop_front();
            check("out_bin", out_bin, e.bin);
            check("out_count", out_count, e.cnt);
            check("out_last", out_last, e.last);
          end
        end else begin
          hold  = 1'b1;
          h_bin = out_bin;
          h_cnt = out_count;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_and_clear();
    rst       = 1'b1;
    pix_valid = 1'b0;
    pix_eof   = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NB; i++) hist[i] = '0;
    tick();
    fill_req = 1'b0;
    @(negedge clk);
    check("rst_pix_ready", pix_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_bin", out_bin, 0);
    check("rst_out_count", out_count, 0);
    check("rst_busy", busy, 1);
    check("rst_ram_b_wr_en", ram_b_wr_en, 0);
    check("rst_ram_a_wr_en", ram_a_wr_en, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      check("clr_wr_en", ram_b_wr_en, 1);
      check("clr_addr", ram_b_addr, i);
      check("clr_data", ram_b_wr_data, 0);
      check("clr_pix_ready", pix_ready, 0);
      check("clr_busy", busy, 1);
    end
    @(negedge clk);
    check("post_clr_pix_ready", pix_ready, 1);
    check("post_clr_busy", busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input logic [AW-1:0] bin, input logic eof);
    int k = 0;
    pix_valid = 1'b1;
    pix_data  = bin;
    pix_eof   = eof;
    while (!pix_ready && k < 100) begin
      tick();
      k++;
    end
    check("pix_accept", pix_ready, 1);
    if (hist[bin] != '1) hist[bin] = hist[bin] + 1;
    if (eof) begin
      for (int i = 0; i < NB; i++) begin
        exp_t x;
        x.bin  = i[AW-1:0];
        x.cnt  = hist[i];
        x.last = (i == NB - 1);
        exp_q.push_back(x);
        hist[i] = '0;
      end
    end
    tick();
  endtask

  task automatic end_pix();
    pix_valid = 1'b0;
    pix_eof   = 1'b0;
  endtask

  task automatic wait_dump(input bit bp);
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < 5000) begin
      out_ready = bp ? ($urandom_range(0, 99) >= 30) : 1'b1;
      tick();
      k++;
    end
    out_ready = 1'b0;
    check("dump_done_in_budget", (k < 5000), 1);
    check("dump_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int k;

    // reset and RAM zeroing
    reset_and_clear();

    // basic frame, twice (second dump shows clear-on-read)
    for (int r = 0; r < 2; r++) begin
      send_pix(8'd3, 1'b0);
      send_pix(8'd7, 1'b0);
      send_pix(8'd3, 1'b0);
      send_pix(8'd200, 1'b1);
      end_pix();
      wait_dump(1'b0);
    end

    // same-bin hazards: distance 1 and distance 2
    for (int i = 0; i < 10; i++) send_pix(8'd5, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send_pix(8'd9, 1'b0);
      send_pix(8'd5, (i == 3));
    end
    end_pix();
    wait_dump(1'b0);

    // saturation through a RAM backdoor preload
    bd_addr = 8'd1;
    bd_data = 32'hFFFF_FFFE;
    bd_req  = 1'b1;
    tick();
    bd_req  = 1'b0;
    hist[1] = 32'hFFFF_FFFE;
    send_pix(8'd1, 1'b0);
    send_pix(8'd1, 1'b0);
    send_pix(8'd1, 1'b1);
    end_pix();
    wait_dump(1'b0);

    // backpressure during the dump
    send_pix(8'd0, 1'b0);
    send_pix(8'd255, 1'b0);
    send_pix(8'd128, 1'b0);
    send_pix(8'd128, 1'b0);
    send_pix(8'd64, 1'b1);
    end_pix();
    wait_dump(1'b1);

    // reset in the middle of a dump
    send_pix(8'd100, 1'b0);
    send_pix(8'd200, 1'b1);
    end_pix();
    k = 0;
    out_ready = 1'b1;
    while (!(out_valid && out_bin == 8'd100) && k < 2000) begin
      tick();
      k++;
    end
    check("reach_bin100", out_bin, 8'd100);
    reset_and_clear();
    send_pix(8'd100, 1'b1);
    end_pix();
    wait_dump(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
